// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_pkg
//  Description : Shared types and constants for the time-setting controller:
//                session state encoding, field widths, default wrap limits
//                and a modular +/-1 helper used for field adjustment.
//  Revision    : 1.0  initial release
// ============================================================================
package time_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SET_H  = 2'd1,
        SET_M  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int DEF_MAX_H = 23;
    localparam int DEF_MAX_M = 59;

    // One step modulo (max_val + 1): max wraps to 0 going up, 0 wraps to
    // max going down, so the result never leaves [0, max_val].
    function automatic logic [7:0] wrap_step(input logic [7:0] value,
                                             input logic [7:0] max_val,
                                             input logic       up);
        if (up) begin
            return (value == max_val) ? 8'd0 : value + 8'd1;
        end
        return (value == 8'd0) ? max_val : value - 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_controller_if
//  Description : Button/time inputs and edit/commit outputs of the
//                time-setting controller.
//                master : drives tick_ms, buttons, cur_h/cur_m; receives the
//                         session outputs.
//                slave  : the controller side.
//  Revision    : 1.0  initial release
// ============================================================================
interface time_set_controller_if;
    import time_pkg::*;

    logic              tick_ms;
    logic              btn_set;
    logic              btn_up;
    logic              btn_down;
    logic [HOUR_W-1:0] cur_h;
    logic [MIN_W-1:0]  cur_m;
    logic              set_active;
    logic              field;
    logic [HOUR_W-1:0] edit_h;
    logic [MIN_W-1:0]  edit_m;
    logic              load;
    logic              blink_on;

    modport master (
        output tick_ms, btn_set, btn_up, btn_down, cur_h, cur_m,
        input  set_active, field, edit_h, edit_m, load, blink_on
    );

    modport slave (
        input  tick_ms, btn_set, btn_up, btn_down, cur_h, cur_m,
        output set_active, field, edit_h, edit_m, load, blink_on
    );
endinterface
`default_nettype wire

// File: rtl/time_set_controller_repeat_timer.sv
`default_nettype none
// ============================================================================
//  Module      : repeat_timer
//  Description : Shared up/down button front end. Detects rising edges and
//                runs the hold/auto-repeat timing, emitting one-cycle step
//                pulses.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_enable        session active; timers clear when low
//                i_tick          1 ms tick
//                i_up, i_down    debounced button levels
//                o_step_up/down  one-cycle step requests
//                o_activity      any up/down edge or repeat step
//  Revision    : 1.0  initial release
// ============================================================================
module repeat_timer #(
    parameter int HOLD_MS = 500,
    parameter int REP_MS  = 100
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_enable,
    input  wire logic i_tick,
    input  wire logic i_up,
    input  wire logic i_down,
    output logic      o_step_up,
    output logic      o_step_down,
    output logic      o_activity
);
    localparam int c_HOLD_W = $clog2(HOLD_MS + 1);
    localparam int c_REP_W  = $clog2(REP_MS + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_MS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_FULL = c_HOLD_W'(HOLD_MS);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REP_MS - 1);

    logic                r_up_q;
    logic                r_down_q;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_REP_W-1:0]  r_rep;

    logic w_up_edge;
    logic w_down_edge;
    logic w_count;
    logic w_saturated;
    logic w_rep_fire;

    assign w_up_edge   = i_up & ~r_up_q;
    assign w_down_edge = i_down & ~r_down_q;
    // Only a single held button advances the timers; both or none clears them.
    assign w_count     = i_enable & (i_up ^ i_down);
    // The hold counter parks at HOLD_MS; from then on the repeat counter paces steps.
    assign w_saturated = (r_hold == c_HOLD_FULL);
    assign w_rep_fire  = w_count & i_tick &
                         (w_saturated ? (r_rep == c_REP_LAST) : (r_hold == c_HOLD_LAST));

    // An edge while the opposite button is down is not a step.
    assign o_step_up   = ~i_down & (w_up_edge | (w_rep_fire & i_up));
    assign o_step_down = ~i_up & (w_down_edge | (w_rep_fire & i_down));
    assign o_activity  = w_up_edge | w_down_edge | w_rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_q   <= 1'b0;
            r_down_q <= 1'b0;
            r_hold   <= '0;
            r_rep    <= '0;
        end else begin
            r_up_q   <= i_up;
            r_down_q <= i_down;
            if (!w_count) begin
                r_hold <= '0;
                r_rep  <= '0;
            end else if (i_tick) begin
                if (!w_saturated) begin
                    r_hold <= r_hold + 1'b1;
                end else if (r_rep == c_REP_LAST) begin
                    r_rep <= '0;
                end else begin
                    r_rep <= r_rep + 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_controller
//  Description : Time-setting session sequencer: hour field, minute field,
//                commit. Captures the running time on entry, edits a working
//                copy with wrap-around and auto-repeat, aborts on inactivity,
//                and emits a one-cycle load strobe plus the field blink.
//  Ports       : CLK    system clock
//                reset  synchronous active-high reset
//                bus    time_set_controller_if.slave (tick_ms, btn_set/up/down,
//                       cur_h/cur_m in; set_active, field, edit_h/edit_m,
//                       load, blink_on out)
//  Revision    : 1.0  initial release
// ============================================================================
module time_set_controller
    import time_pkg::*;
#(
    parameter int MAX_H      = DEF_MAX_H,
    parameter int MAX_M      = DEF_MAX_M,
    parameter int HOLD_MS    = 500,
    parameter int REP_MS     = 100,
    parameter int TIMEOUT_MS = 10000,
    parameter int BLINK_MS   = 250
) (
    input wire logic             CLK,
    input wire logic             reset,
    time_set_controller_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] c_ST_SET_H  = 2'(SET_H);
    localparam logic [1:0] c_ST_SET_M  = 2'(SET_M);
    localparam logic [1:0] c_ST_COMMIT = 2'(COMMIT);

    localparam int c_TO_W    = $clog2(TIMEOUT_MS + 1);
    localparam int c_BLINK_W = $clog2(BLINK_MS + 1);
    localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(TIMEOUT_MS - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_MS - 1);

    logic [1:0]           r_state;
    logic                 r_set_q;
    logic [HOUR_W-1:0]    r_edit_h;
    logic [MIN_W-1:0]     r_edit_m;
    logic                 r_load;
    logic                 r_blink;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic [c_TO_W-1:0]    r_inact;

    logic w_set_edge;
    logic w_in_session;
    logic w_step_up;
    logic w_step_down;
    logic w_activity;
    logic w_timeout;

    assign w_set_edge   = bus.btn_set & ~r_set_q;
    assign w_in_session = (r_state == c_ST_SET_H) | (r_state == c_ST_SET_M);
    assign w_timeout    = bus.tick_ms & ~w_activity & (r_inact == c_TO_LAST);

    repeat_timer #(
        .HOLD_MS (HOLD_MS),
        .REP_MS  (REP_MS)
    ) u_repeat_timer (
        .clk         (CLK),
        .rst         (reset),
        .i_enable    (w_in_session),
        .i_tick      (bus.tick_ms),
        .i_up        (bus.btn_up),
        .i_down      (bus.btn_down),
        .o_step_up   (w_step_up),
        .o_step_down (w_step_down),
        .o_activity  (w_activity)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_set_q     <= 1'b0;
            r_edit_h    <= '0;
            r_edit_m    <= '0;
            r_load      <= 1'b0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
            r_inact     <= '0;
        end else begin
            r_set_q <= bus.btn_set;
            r_load  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_blink     <= 1'b0;
                    r_blink_cnt <= '0;
                    r_inact     <= '0;
                    if (w_set_edge) begin
                        r_edit_h <= bus.cur_h;
                        r_edit_m <= bus.cur_m;
                        r_state  <= c_ST_SET_H;
                        r_blink  <= 1'b1;
                    end
                end
                c_ST_SET_H, c_ST_SET_M: begin
                    // Set has priority: any coincident step is dropped.
                    if (w_set_edge) begin
                        r_inact     <= '0;
                        r_blink_cnt <= '0;
                        if (r_state == c_ST_SET_H) begin
                            r_state <= c_ST_SET_M;
                            r_blink <= 1'b1;
                        end else begin
                            r_state <= c_ST_COMMIT;
                            r_blink <= 1'b0;
                            r_load  <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= c_ST_IDLE;
                        r_blink     <= 1'b0;
                        r_blink_cnt <= '0;
                        r_inact     <= '0;
                    end else begin
                        if (w_activity) begin
                            r_inact <= '0;
                        end else if (bus.tick_ms) begin
                            r_inact <= r_inact + 1'b1;
                        end
                        if (w_step_up | w_step_down) begin
                            if (r_state == c_ST_SET_H) begin
                                r_edit_h <= HOUR_W'(wrap_step(8'(r_edit_h), 8'(MAX_H), w_step_up));
                            end else begin
                                r_edit_m <= MIN_W'(wrap_step(8'(r_edit_m), 8'(MAX_M), w_step_up));
                            end
                            r_blink     <= 1'b1;
                            r_blink_cnt <= '0;
                        end else if (bus.tick_ms) begin
                            if (r_blink_cnt == c_BLINK_LAST) begin
                                r_blink     <= ~r_blink;
                                r_blink_cnt <= '0;
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // COMMIT lasts one cycle; load is already high.
                    r_state <= c_ST_IDLE;
                    r_blink <= 1'b0;
                end
            endcase
        end
    end

    assign bus.set_active = w_in_session;
    assign bus.field      = (r_state == c_ST_SET_M);
    assign bus.edit_h     = r_edit_h;
    assign bus.edit_m     = r_edit_m;
    assign bus.load       = r_load;
    assign bus.blink_on   = r_blink;
endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set_controller
//  Description : Self-checking bench for time_set_controller. A behavioural
//                model tracks session mode, held-tick counts, idle time and
//                blink phase with plain arithmetic; every cycle the DUT
//                outputs are compared against it. Directed scenarios add
//                literal expectations, followed by a randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_time_set_controller;
    localparam int MAX_H      = 23;
    localparam int MAX_M      = 59;
    localparam int HOLD_MS    = 500;
    localparam int REP_MS     = 100;
    localparam int TIMEOUT_MS = 10000;
    localparam int BLINK_MS   = 250;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    time_set_controller_if bus();

    time_set_controller #(
        .MAX_H      (MAX_H),
        .MAX_M      (MAX_M),
        .HOLD_MS    (HOLD_MS),
        .REP_MS     (REP_MS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .BLINK_MS   (BLINK_MS)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;
    int n_load   = 0;
    bit armed    = 1'b0;

    // Model: mode 0 idle, 1 hours, 2 minutes, 3 commit.
    int m_mode, m_h, m_m, m_hold, m_inact, m_since;
    bit m_load, m_blink, m_ps, m_pu, m_pd;

    always @(posedge CLK) begin : model
        bit t, u, d, se, ue, de, rep, su, sd, act, in_s;
        t = bus.tick_ms;
        u = bus.btn_up;
        d = bus.btn_down;
        if (reset) begin
            m_mode = 0; m_h = 0; m_m = 0; m_load = 0; m_blink = 0;
            m_hold = 0; m_inact = 0; m_since = 0;
            m_ps = 0; m_pu = 0; m_pd = 0;
            armed = 1'b1;
        end else begin
            se   = bus.btn_set && !m_ps;
            ue   = u && !m_pu;
            de   = d && !m_pd;
            in_s = (m_mode == 1) || (m_mode == 2);
            rep  = 0;
            if (in_s && (u != d)) begin
                if (t) begin
                    m_hold++;
                    rep = (m_hold >= HOLD_MS) && (((m_hold - HOLD_MS) % REP_MS) == 0);
                end
            end else begin
                m_hold = 0;
            end
            su  = !d && (ue || (rep && u));
            sd  = !u && (de || (rep && d));
            act = ue || de || rep;
            m_load = 0;
            case (m_mode)
                0: begin
                    if (se) begin
                        m_h = int'(bus.cur_h); m_m = int'(bus.cur_m);
                        m_mode = 1; m_blink = 1; m_since = 0; m_inact = 0;
                    end
                end
                1, 2: begin
                    if (se) begin
                        m_inact = 0;
                        if (m_mode == 1) begin
                            m_mode = 2; m_blink = 1; m_since = 0;
                        end else begin
                            m_mode = 3; m_blink = 0; m_load = 1;
                        end
                    end else if (t && !act && (m_inact + 1 >= TIMEOUT_MS)) begin
                        m_mode = 0; m_blink = 0;
                    end else begin
                        if (act) m_inact = 0;
                        else if (t) m_inact++;
                        if (su || sd) begin
                            if (m_mode == 1) m_h = su ? (m_h + 1) % (MAX_H + 1) : (m_h + MAX_H) % (MAX_H + 1);
                            else             m_m = su ? (m_m + 1) % (MAX_M + 1) : (m_m + MAX_M) % (MAX_M + 1);
                            m_blink = 1; m_since = 0;
                        end else if (t) begin
                            m_since++;
                            m_blink = ((m_since / BLINK_MS) % 2) == 0;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
            m_ps = bus.btn_set; m_pu = u; m_pd = d;
        end
    end

    logic [14:0] act_v, exp_v;
    always @(negedge CLK) begin
        if (armed) begin
            act_v = {bus.set_active, bus.field, bus.edit_h, bus.edit_m, bus.load, bus.blink_on};
            exp_v = {(m_mode == 1) || (m_mode == 2), m_mode == 2, 5'(m_h), 6'(m_m), m_load, m_blink};
            n_checks++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL outputs @%0t: got act/fld/h/m/ld/bl=%b/%b/%0d/%0d/%b/%b required %b/%b/%0d/%0d/%b/%b",
                         $time, act_v[14], act_v[13], act_v[12:8], act_v[7:2], act_v[1], act_v[0],
                         exp_v[14], exp_v[13], exp_v[12:8], exp_v[7:2], exp_v[1], exp_v[0]);
            end
            if (bus.load === 1'b1) n_load++;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_ms = 1'b1;
            @(negedge CLK);
            bus.tick_ms = 1'b0;
            @(negedge CLK);
        end
    endtask

    // Raise the selected buttons for one cycle, then drop them for one cycle.
    task automatic tap(input bit s, input bit u, input bit d);
        bus.btn_set = s; bus.btn_up = u; bus.btn_down = d;
        @(negedge CLK);
        bus.btn_set = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int loads_before;

    initial begin
        bus.tick_ms = 0; bus.btn_set = 0; bus.btn_up = 0; bus.btn_down = 0;
        bus.cur_h = '0; bus.cur_m = '0;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_set_active", int'(bus.set_active), 0);
        chk("reset_blink", int'(bus.blink_on), 0);
        reset = 1'b0;
        @(negedge CLK);

        // Reset in the middle of the minute field.
        bus.cur_h = 5'd7; bus.cur_m = 6'd8;
        tap(1, 0, 0);
        tap(1, 0, 0);
        chk("pre_reset_field", int'(bus.field), 1);
        chk("pre_reset_edit_m", int'(bus.edit_m), 8);
        loads_before = n_load;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("mid_reset_outputs",
                int'({bus.set_active, bus.field, bus.edit_h, bus.edit_m, bus.load, bus.blink_on}), 0);
        end
        reset = 1'b0;
        @(negedge CLK);
        chk("post_reset_idle", int'(bus.set_active), 0);
        chk("reset_no_load", n_load - loads_before, 0);

        // 13:45 -> up x2 -> down x1 -> commit 15:44.
        bus.cur_h = 5'd13; bus.cur_m = 6'd45;
        tap(1, 0, 0);
        chk("capture_h", int'(bus.edit_h), 13);
        tap(0, 1, 0);
        tap(0, 1, 0);
        tap(1, 0, 0);
        tap(0, 0, 1);
        bus.btn_set = 1'b1;
        @(negedge CLK);
        chk("commit_load", int'(bus.load), 1);
        chk("commit_edit_h", int'(bus.edit_h), 15);
        chk("commit_edit_m", int'(bus.edit_m), 44);
        bus.btn_set = 1'b0;
        @(negedge CLK);
        chk("commit_load_drop", int'(bus.load), 0);
        chk("commit_idle", int'(bus.set_active), 0);

        // Wrap limits.
        bus.cur_h = 5'd23; bus.cur_m = 6'd0;
        tap(1, 0, 0);
        tap(0, 1, 0);
        chk("wrap_h_up", int'(bus.edit_h), 0);
        tap(1, 0, 0);
        tap(0, 0, 1);
        chk("wrap_m_down", int'(bus.edit_m), 59);
        tap(1, 0, 0);

        // Hold up: press edge takes 9 -> 10, then repeats at 500,600..1000.
        bus.cur_h = 5'd0; bus.cur_m = 6'd9;
        tap(1, 0, 0);
        tap(1, 0, 0);
        bus.btn_up = 1'b1;
        run_ticks(499);
        chk("hold_before_500", int'(bus.edit_m), 10);
        run_ticks(1);
        chk("hold_at_500", int'(bus.edit_m), 11);
        run_ticks(500);
        chk("hold_at_1000", int'(bus.edit_m), 16);
        bus.btn_up = 1'b0;
        @(negedge CLK);

        // Both held: nothing moves.
        bus.btn_up = 1'b1; bus.btn_down = 1'b1;
        run_ticks(2000);
        chk("both_held", int'(bus.edit_m), 16);
        bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        @(negedge CLK);
        tap(1, 0, 0);

        // Set coincident with up in the hour field: field advances, no step.
        bus.cur_h = 5'd5; bus.cur_m = 6'd30;
        tap(1, 0, 0);
        tap(1, 1, 0);
        chk("coincide_field", int'(bus.field), 1);
        chk("coincide_edit_h", int'(bus.edit_h), 5);
        tap(1, 0, 0);

        // Blink cadence and inactivity timeout in the hour field.
        loads_before = n_load;
        tap(1, 0, 0);
        chk("blink_entry", int'(bus.blink_on), 1);
        run_ticks(249);
        chk("blink_249", int'(bus.blink_on), 1);
        run_ticks(1);
        chk("blink_250", int'(bus.blink_on), 0);
        run_ticks(250);
        chk("blink_500", int'(bus.blink_on), 1);
        run_ticks(9499);
        chk("timeout_9999", int'(bus.set_active), 1);
        run_ticks(1);
        chk("timeout_10000", int'(bus.set_active), 0);
        chk("timeout_blink", int'(bus.blink_on), 0);
        chk("timeout_no_load", n_load - loads_before, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.tick_ms = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) bus.btn_set  = ~bus.btn_set;
            if ($urandom_range(0, 14) == 0) bus.btn_up   = ~bus.btn_up;
            if ($urandom_range(0, 14) == 0) bus.btn_down = ~bus.btn_down;
            bus.cur_h = 5'($urandom_range(0, MAX_H));
            bus.cur_m = 6'($urandom_range(0, MAX_M));
            reset = ($urandom_range(0, 1499) == 0);
            @(negedge CLK);
        end
        reset = 1'b0;
        bus.tick_ms = 0; bus.btn_set = 0; bus.btn_up = 0; bus.btn_down = 0;
        repeat (4) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
